conv2d_stream_engine: RTL and testbench



---
 rtl/conv2d_stream_engine_if.sv | 27 ++
 rtl/conv2d_stream_engine.sv | 181 ++++++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_stream_engine_if.sv
// Command, load and result handshake bundle for conv2d_stream_engine.
// The host side drives commands/elements and consumes results.
interface conv2d_stream_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
);
    logic                  cmd_valid;
    logic [1:0]            cmd;
    logic                  cmd_ready;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [ACC_WIDTH-1:0]  out_data;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        output cmd_valid, cmd, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  cmd_valid, cmd, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv2d_stream_engine.sv
// Streaming valid-window 2-D convolution engine with register-held kernel
// and matrix, one multiply-accumulate tap per cycle.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module conv2d_stream_engine #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int MATRIX_DIM = 16,
    parameter int CONV_DIM   = 3,
    parameter int STRIDE     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    conv2d_stream_engine_if.slave bus,
    output logic                 busy,
    output logic                 done
);
    localparam int OUT_DIM   = (MATRIX_DIM - CONV_DIM) / STRIDE + 1;
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(CONV_DIM * CONV_DIM);
    localparam int MW = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1;
    localparam int KW = (CONV_DIM > 1) ? $clog2(CONV_DIM) : 1;

    localparam logic [KW-1:0] KLAST   = KW'(CONV_DIM - 1);
    localparam logic [MW-1:0] KLAST_M = MW'(CONV_DIM - 1);
    localparam logic [MW-1:0] MLAST   = MW'(MATRIX_DIM - 1);
    localparam logic [MW-1:0] OLAST   = MW'(OUT_DIM - 1);

    if (CONV_DIM > MATRIX_DIM) begin : g_bad_dim
        $error("CONV_DIM must not exceed MATRIX_DIM");
    end
    if (((MATRIX_DIM - CONV_DIM) % STRIDE) != 0) begin : g_bad_stride
        $error("(MATRIX_DIM-CONV_DIM) must be a multiple of STRIDE");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_LOAD_M,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t state, state_nx;

    logic signed [DATA_WIDTH-1:0] kmem [CONV_DIM][CONV_DIM];
    logic signed [DATA_WIDTH-1:0] mmem [MATRIX_DIM][MATRIX_DIM];

    logic [MW-1:0] lx, ly;
    logic [KW-1:0] kx, ky;
    logic [MW-1:0] ox, oy;
    logic [MW-1:0] row, col;
    logic signed [ACC_WIDTH-1:0] acc, kext, mext, prod;
    logic last;

    // Window base plus tap offset selects the matrix element for this cycle.
    assign row  = MW'(int'(oy) * STRIDE + int'(ky));
    assign col  = MW'(int'(ox) * STRIDE + int'(kx));
    assign kext = ACC_WIDTH'(kmem[ky][kx]);
    assign mext = ACC_WIDTH'(mmem[row][col]);
    assign prod = kext * mext;

    assign last = (state == S_OUTPUT) && (ox == OLAST) && (oy == OLAST);

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.in_ready  = (state == S_LOAD_K) || (state == S_LOAD_M);
    assign bus.out_valid = (state == S_OUTPUT);
    assign bus.out_data  = (state == S_OUTPUT) ? acc : '0;
    assign bus.out_last  = last;
    assign busy          = (state != S_IDLE);
    assign done          = last && bus.out_ready;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    unique case (bus.cmd)
                        2'd0:    state_nx = S_LOAD_K;
                        2'd1:    state_nx = S_LOAD_M;
                        2'd2:    state_nx = S_COMPUTE;
                        default: state_nx = S_IDLE;
                    endcase
                end
            end
            S_LOAD_K: begin
                if (bus.in_valid && lx == KLAST_M && ly == KLAST_M)
                    state_nx = S_IDLE;
            end
            S_LOAD_M: begin
                if (bus.in_valid && lx == MLAST && ly == MLAST)
                    state_nx = S_IDLE;
            end
            S_COMPUTE: begin
                if (kx == KLAST && ky == KLAST)
                    state_nx = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (bus.out_ready)
                    state_nx = last ? S_IDLE : S_COMPUTE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            lx    <= '0;
            ly    <= '0;
            kx    <= '0;
            ky    <= '0;
            ox    <= '0;
            oy    <= '0;
            acc   <= '0;
            for (int y = 0; y < CONV_DIM; y++)
                for (int x = 0; x < CONV_DIM; x++)
                    kmem[y][x] <= '0;
            for (int y = 0; y < MATRIX_DIM; y++)
                for (int x = 0; x < MATRIX_DIM; x++)
                    mmem[y][x] <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        lx <= '0;
                        ly <= '0;
                        kx <= '0;
                        ky <= '0;
                        ox <= '0;
                        oy <= '0;
                    end
                end
                S_LOAD_K: begin
                    if (bus.in_valid) begin
                        kmem[KW'(ly)][KW'(lx)] <= $signed(bus.in_data);
                        if (lx == KLAST_M) begin
                            lx <= '0;
                            ly <= ly + 1'b1;
                        end else begin
                            lx <= lx + 1'b1;
                        end
                    end
                end
                S_LOAD_M: begin
                    if (bus.in_valid) begin
                        mmem[ly][lx] <= $signed(bus.in_data);
                        if (lx == MLAST) begin
                            lx <= '0;
                            ly <= ly + 1'b1;
                        end else begin
                            lx <= lx + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    acc <= (kx == '0 && ky == '0) ? prod : acc + prod;
                    if (kx == KLAST) begin
                        kx <= '0;
                        ky <= (ky == KLAST) ? '0 : ky + 1'b1;
                    end else begin
                        kx <= kx + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    // Taps are already back at zero after the last compute tap.
                    if (bus.out_ready && !last) begin
                        if (ox == OLAST) begin
                            ox <= '0;
                            oy <= oy + 1'b1;
                        end else begin
                            ox <= ox + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Self-checking bench for conv2d_stream_engine: table-driven runs on a
// 4/3/1 instance, a stride-2 5/3/2 instance, and handshake corner cases.
module tb_conv2d_stream_engine;
    localparam int DW = 8;
    localparam int AW = 20;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [71:0]  k;
        logic [127:0] m;
        bit           ld_k;
        bit           ld_m;
        bit           gaps;
        bit           hold;
        logic [127:0] e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic busy_a, done_a, busy_b, done_b;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   done_cnt = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    vec_t tv[4];

    always #5 clk = ~clk;

    conv2d_stream_engine_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) ia ();
    conv2d_stream_engine_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) ib ();

    conv2d_stream_engine #(
        .DATA_WIDTH(DW), .MATRIX_DIM(4), .CONV_DIM(3), .STRIDE(1)
    ) u_a (
        .clk(clk), .rst(rst), .bus(ia.slave), .busy(busy_a), .done(done_a)
    );

    conv2d_stream_engine #(
        .DATA_WIDTH(DW), .MATRIX_DIM(5), .CONV_DIM(3), .STRIDE(2)
    ) u_b (
        .clk(clk), .rst(rst), .bus(ib.slave), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d want %0d", nm, $signed(act), $signed(exp));
    endtask

    function automatic logic [31:0] sx(input logic [AW-1:0] v);
        return 32'($signed(v));
    endfunction

    function automatic logic [71:0] k_fill(input logic [7:0] v, input bit centre);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = (centre && i != 4) ? 8'd0 : v;
        return r;
    endfunction

    function automatic logic [127:0] m_raster();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(i);
        return r;
    endfunction

    function automatic logic [127:0] m_const(input logic [7:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [127:0] pack4(input int a, input int b,
                                           input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    task automatic push_a(input logic [127:0] e);
        for (int i = 0; i < 4; i++) qa.push_back('{e[i*32 +: 32], i == 3});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && ia.out_valid && ia.out_ready) begin
            if (qa.size() == 0) begin
                check("a_extra_result", 1, 0);
            end else begin
                ea = qa.pop_front();
                check("a_data", sx(ia.out_data), ea.data);
                check("a_last", 32'(ia.out_last), 32'(ea.last));
                check("a_done", 32'(done_a), 32'(ea.last));
            end
        end
        if (done_a) done_cnt++;
    end

    always @(negedge clk) begin
        if (!rst && ib.out_valid && ib.out_ready) begin
            if (qb.size() == 0) begin
                check("b_extra_result", 1, 0);
            end else begin
                eb = qb.pop_front();
                check("b_data", sx(ib.out_data), eb.data);
                check("b_last", 32'(ib.out_last), 32'(eb.last));
                check("b_done", 32'(done_b), 32'(eb.last));
            end
        end
    end

    task automatic issue_a(input logic [1:0] c);
        check("a_cmd_ready", 32'(ia.cmd_ready), 1);
        ia.cmd_valid = 1'b1;
        ia.cmd = c;
        step();
        ia.cmd_valid = 1'b0;
    endtask

    task automatic issue_b(input logic [1:0] c);
        check("b_cmd_ready", 32'(ib.cmd_ready), 1);
        ib.cmd_valid = 1'b1;
        ib.cmd = c;
        step();
        ib.cmd_valid = 1'b0;
    endtask

    task automatic load_a(input logic [1:0] c, input logic [127:0] vals,
                          input int n, input bit gaps);
        int i;
        int g;
        bit v;
        issue_a(c);
        i = 0;
        g = 0;
        while (i < n && g < 2000) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ia.in_valid = v;
            ia.in_data = vals[i*8 +: 8];
            step();
            if (v) i++;
            g++;
        end
        ia.in_valid = 1'b0;
        check("load_len", i, n);
        check("load_idle", 32'(ia.cmd_ready), 1);
    endtask

    task automatic run_a(input bit hold);
        int n;
        int d0;
        d0 = done_cnt;
        ia.out_ready = !hold;
        issue_a(2'd2);
        check("busy_run", 32'(busy_a), 1);
        for (int r = 0; r < 4; r++) begin
            n = 0;
            while (!ia.out_valid && n < 40) begin
                step();
                n++;
            end
            check("latency", n, 9);
            if (hold && r == 0) begin
                for (int h = 0; h < 5; h++) begin
                    check("hold_valid", 32'(ia.out_valid), 1);
                    check("hold_data", sx(ia.out_data), qa.size() > 0 ? qa[0].data : 32'hdead);
                    step();
                end
                ia.out_ready = 1'b1;
            end
            step();
        end
        check("busy_end", 32'(busy_a), 0);
        check("done_once", done_cnt - d0, 1);
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (qa.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("drain", qa.size(), 0);
        check("drain_idle", 32'(busy_a), 0);
    endtask

    initial begin
        int n;
        tv[0] = '{k_fill(8'd1, 1'b0), m_raster(), 1'b1, 1'b1, 1'b1, 1'b0,
                  pack4(45, 54, 81, 90)};
        tv[1] = '{72'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b1,
                  pack4(45, 54, 81, 90)};
        tv[2] = '{k_fill(8'd1, 1'b1), 128'd0, 1'b1, 1'b0, 1'b0, 1'b0,
                  pack4(5, 6, 9, 10)};
        tv[3] = '{k_fill(8'hFF, 1'b0), m_const(8'd127), 1'b1, 1'b1, 1'b0, 1'b0,
                  pack4(-1143, -1143, -1143, -1143)};

        ia.cmd_valid = 1'b0; ia.cmd = 2'd0; ia.in_valid = 1'b0;
        ia.in_data = '0; ia.out_ready = 1'b1;
        ib.cmd_valid = 1'b0; ib.cmd = 2'd0; ib.in_valid = 1'b0;
        ib.in_data = '0; ib.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        check("rst_cmd_ready", 32'(ia.cmd_ready), 1);
        check("rst_in_ready", 32'(ia.in_ready), 0);
        check("rst_out_valid", 32'(ia.out_valid), 0);
        check("rst_out_last", 32'(ia.out_last), 0);
        check("rst_out_data", sx(ia.out_data), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        rst = 1'b0;
        step();

        push_a(pack4(0, 0, 0, 0));
        run_a(1'b0);

        for (int t = 0; t < 4; t++) begin
            if (tv[t].ld_k) load_a(2'd0, {56'd0, tv[t].k}, 9, tv[t].gaps);
            if (tv[t].ld_m) load_a(2'd1, tv[t].m, 16, 1'b0);
            push_a(tv[t].e);
            run_a(tv[t].hold);
        end

        push_a(pack4(-1143, -1143, -1143, -1143));
        issue_a(2'd2);
        step();
        step();
        ia.cmd_valid = 1'b1; ia.cmd = 2'd2;
        ia.in_valid = 1'b1; ia.in_data = 8'd55;
        check("cmd_ready_compute", 32'(ia.cmd_ready), 0);
        check("in_ready_compute", 32'(ia.in_ready), 0);
        step(); step(); step();
        ia.cmd_valid = 1'b0;
        ia.in_valid = 1'b0;
        drain_a();
        push_a(pack4(-1143, -1143, -1143, -1143));
        run_a(1'b0);

        issue_a(2'd3);
        check("cmd3_busy", 32'(busy_a), 0);
        check("cmd3_ready", 32'(ia.cmd_ready), 1);
        step(); step();
        check("cmd3_no_out", 32'(ia.out_valid), 0);

        ib.out_ready = 1'b1;
        issue_b(2'd0);
        for (int i = 0; i < 9; i++) begin
            ib.in_valid = 1'b1;
            ib.in_data = (i == 4) ? 8'd1 : 8'd0;
            step();
        end
        ib.in_valid = 1'b0;
        issue_b(2'd1);
        for (int i = 0; i < 25; i++) begin
            ib.in_valid = 1'b1;
            ib.in_data = 8'(i);
            step();
        end
        ib.in_valid = 1'b0;
        qb.push_back('{32'd6, 1'b0});
        qb.push_back('{32'd8, 1'b0});
        qb.push_back('{32'd16, 1'b0});
        qb.push_back('{32'd18, 1'b1});
        issue_b(2'd2);
        n = 0;
        while (qb.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("b_drain", qb.size(), 0);
        check("b_idle", 32'(busy_b), 0);

        push_a(pack4(-1143, -1143, -1143, -1143));
        issue_a(2'd2);
        n = 0;
        while (!ia.out_valid && n < 40) begin
            step();
            n++;
        end
        step();
        repeat (4) step();
        rst = 1'b1;
        qa.delete();
        step();
        check("midrun_rst_valid", 32'(ia.out_valid), 0);
        check("midrun_rst_busy", 32'(busy_a), 0);
        rst = 1'b0;
        step();
        push_a(pack4(0, 0, 0, 0));
        run_a(1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
